adr_fifo_reader: RTL and testbench

Read-side controller for the show-ahead address FIFO. It pops entries whenever downstream can accept them and presents each address on a valid/ready output through a 2-entry skid stage. It also returns consumed-slot credits to the remote writer in batches. It sits between the address FIFO (`empty`/`r_data`/`rd`) and the memory-request issue logic.

---
 rtl/adr_rd_pkg.sv | 15 +
 rtl/adr_rd_skid.sv | 75 +++++++
 rtl/adr_fifo_reader.sv | 105 ++++++++++
 tb/tb_adr_fifo_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adr_rd_pkg.sv
// adr_rd_pkg: shared constants for the address FIFO reader.
// Skid occupancy encoding and credit defaults.
package adr_rd_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } occ_e;

  localparam int CREDIT_CNT_W       = 8;
  localparam int DEF_CREDIT_BATCH   = 4;
  localparam int DEF_CREDIT_TIMEOUT = 16;

endpackage

// File: rtl/adr_rd_skid.sv
// adr_rd_skid: 2-entry skid buffer with valid/ready output.
// r_q0 is always the head (older) word.
module adr_rd_skid
  import adr_rd_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_occ
);

  occ_e             r_occ;
  occ_e             w_occ_nxt;
  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] w_q0_nxt;
  logic [WIDTH-1:0] w_q1_nxt;
  logic             w_drain;

  assign o_valid = (r_occ != S0);
  assign o_data  = r_q0;
  assign o_occ   = r_occ;
  assign w_drain = o_valid & i_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    w_q0_nxt  = r_q0;
    w_q1_nxt  = r_q1;
    unique case (r_occ)
      S0: begin
        if (i_push) begin
          w_q0_nxt  = i_data;
          w_occ_nxt = S1;
        end
      end
      S1: begin
        if (i_push && w_drain) begin
          w_q0_nxt = i_data;
        end else if (i_push) begin
          w_q1_nxt  = i_data;
          w_occ_nxt = S2;
        end else if (w_drain) begin
          w_occ_nxt = S0;
        end
      end
      S2: begin
        // no push can arrive here; the caller gates it on S2
        if (w_drain) begin
          w_q0_nxt  = r_q1;
          w_occ_nxt = S1;
        end
      end
      default: w_occ_nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= S0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      r_q0  <= w_q0_nxt;
      r_q1  <= w_q1_nxt;
    end
  end

endmodule

// File: rtl/adr_fifo_reader.sv
// adr_fifo_reader: pops the address FIFO into a skid, returns credits.
// Optional rd_count output under ADR_FIFO_READER_STATS_EN.
module adr_fifo_reader
  import adr_rd_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int CREDIT_BATCH   = DEF_CREDIT_BATCH,
  parameter int CREDIT_TIMEOUT = DEF_CREDIT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [WIDTH-1:0]        fifo_r_data,
  output logic                    fifo_rd,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic                    credit_valid,
  output logic [CREDIT_CNT_W-1:0] credit_cnt
`ifdef ADR_FIFO_READER_STATS_EN
  ,
  output logic [31:0]             rd_count
`endif
);

  localparam logic [CREDIT_CNT_W-1:0] LP_BATCH =
    CREDIT_CNT_W'(CREDIT_BATCH);
  localparam logic [CREDIT_CNT_W:0] LP_TMO =
    (CREDIT_CNT_W+1)'(CREDIT_TIMEOUT);

  logic [1:0]              w_occ;
  logic                    w_pop;
  logic                    w_drain;
  logic [CREDIT_CNT_W-1:0] r_acc;
  logic [CREDIT_CNT_W-1:0] r_tmr;
  logic                    r_cv;
  logic [CREDIT_CNT_W-1:0] r_cc;
  logic [CREDIT_CNT_W-1:0] w_sum;
  logic                    w_tmo;
  logic                    w_emit;

  assign w_pop   = ~fifo_empty & (w_occ != S2) & ~reset;
  assign fifo_rd = w_pop;
  assign w_drain = out_valid & out_ready;

  adr_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_pop),
    .i_data  (fifo_r_data),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_occ   (w_occ)
  );

  // Timer is zero in the first idle cycle after a pop, so the
  // forced return lands CREDIT_TIMEOUT cycles after that pop.
  assign w_sum  = r_acc + {{(CREDIT_CNT_W-1){1'b0}}, w_pop};
  assign w_tmo  = (r_acc != '0) &&
                  (({1'b0, r_tmr} + 2) >= LP_TMO);
  assign w_emit = (w_sum >= LP_BATCH) || w_tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_tmr <= '0;
      r_cv  <= 1'b0;
      r_cc  <= '0;
    end else begin
      r_cv <= w_emit;
      r_cc <= w_emit ? w_sum : '0;
      r_acc <= w_emit ? '0 : w_sum;
      if (w_emit || w_pop) begin
        r_tmr <= '0;
      end else if (r_acc != '0) begin
        r_tmr <= r_tmr + 1'b1;
      end else begin
        r_tmr <= '0;
      end
    end
  end

  assign credit_valid = r_cv;
  assign credit_cnt   = r_cc;

`ifdef ADR_FIFO_READER_STATS_EN
  logic [31:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_count <= '0;
    end else if (w_drain && (r_rd_count != '1)) begin
      r_rd_count <= r_rd_count + 1'b1;
    end
  end

  assign rd_count = r_rd_count;
`else
  // accept counter not built
`endif

endmodule

// File: tb/tb_adr_fifo_reader.sv
// tb_adr_fifo_reader: table vectors, directed corners, random vs model.
// Model: queues for FIFO and skid, pop-count/idle-cycle credit rule.
module tb_adr_fifo_reader;

  localparam int W     = 64;
  localparam int BATCH = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_r_data = '0;
  logic          out_ready = 1'b0;
  logic          fifo_rd;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          credit_valid;
  logic [7:0]    credit_cnt;
`ifdef ADR_FIFO_READER_STATS_EN
  logic [31:0]   rd_count;
`endif

  always #5 clk = ~clk;

  adr_fifo_reader #(
    .WIDTH          (W),
    .CREDIT_BATCH   (BATCH),
    .CREDIT_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_rd      (fifo_rd),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .credit_valid (credit_valid),
    .credit_cnt   (credit_cnt)
`ifdef ADR_FIFO_READER_STATS_EN
    ,
    .rd_count     (rd_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fifoq[$];
  logic [W-1:0] skq[$];
  int           pend = 0;
  int           lastpop = 0;
  int           cyc = 0;
  logic         m_cv = 1'b0;
  logic [7:0]   m_cc = '0;
  logic [31:0]  m_rdc = '0;

  logic         s_rd;
  logic         s_vld;
  logic [W-1:0] s_dat;
  logic         s_cv;
  logic [7:0]   s_cc;

  typedef struct {
    logic         rdy;
    logic         rd;
    logic         vld;
    logic [W-1:0] dat;
    logic         cv;
    logic [7:0]   cc;
  } vec_t;

  vec_t tab[20];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic e_rd;
    logic e_vld;
    logic acc;
    int   sum;
    bit   tmo;
    fifo_empty  = (fifoq.size() == 0);
    fifo_r_data = fifo_empty ? '0 : fifoq[0];
    @(negedge clk);
    s_rd  = fifo_rd;
    s_vld = out_valid;
    s_dat = out_data;
    s_cv  = credit_valid;
    s_cc  = credit_cnt;
    e_rd  = !reset && (fifoq.size() != 0) && (skq.size() < 2);
    e_vld = (skq.size() != 0);
    chk("fifo_rd", W'(s_rd), W'(e_rd));
    chk("out_valid", W'(s_vld), W'(e_vld));
    if (e_vld) chk("out_data", s_dat, skq[0]);
    chk("credit_valid", W'(s_cv), W'(m_cv));
    chk("credit_cnt", W'(s_cc), W'(m_cc));
`ifdef ADR_FIFO_READER_STATS_EN
    chk("rd_count", W'(rd_count), W'(m_rdc));
`endif
    if (reset) begin
      skq.delete();
      pend  = 0;
      m_cv  = 1'b0;
      m_cc  = '0;
      m_rdc = '0;
    end else begin
      acc = e_vld && out_ready;
      sum = pend + int'(e_rd);
      tmo = (pend > 0) && ((cyc - lastpop) >= TMO - 1);
      if (sum >= BATCH || tmo) begin
        m_cv = 1'b1;
        m_cc = 8'(sum);
        pend = 0;
      end else begin
        m_cv = 1'b0;
        m_cc = '0;
        pend = sum;
      end
      if (e_rd) lastpop = cyc;
      if (acc) begin
        void'(skq.pop_front());
        if (m_rdc != '1) m_rdc++;
      end
      if (e_rd) skq.push_back(fifoq.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fifoq.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int           n;
    logic [W-1:0] got[$];

    for (int i = 0; i < 20; i++) begin
      tab[i] = '{1'b1, 1'b0, 1'b0, '0, 1'b0, 8'd0};
    end
    tab[0] = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 8'd0};
    tab[1] = '{1'b1, 1'b1, 1'b1, 64'hA0, 1'b0, 8'd0};
    tab[2] = '{1'b1, 1'b1, 1'b1, 64'hA1, 1'b0, 8'd0};
    tab[3] = '{1'b1, 1'b0, 1'b1, 64'hA2, 1'b0, 8'd0};
    tab[18].cv = 1'b1;
    tab[18].cc = 8'd3;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    tick();
    chk("rst_out_data", s_dat, '0);
    chk("rst_valid", W'(s_vld), '0);
    chk("rst_credit", W'(s_cv), '0);

    // three-word burst and its timeout credit
    fifoq.push_back(64'hA0);
    fifoq.push_back(64'hA1);
    fifoq.push_back(64'hA2);
    for (int i = 0; i < 20; i++) begin
      out_ready = tab[i].rdy;
      tick();
      chk("t_rd", W'(s_rd), W'(tab[i].rd));
      chk("t_vld", W'(s_vld), W'(tab[i].vld));
      if (tab[i].vld) chk("t_dat", s_dat, tab[i].dat);
      chk("t_cv", W'(s_cv), W'(tab[i].cv));
      chk("t_cc", W'(s_cc), W'(tab[i].cc));
    end

    // backpressure: two pops, head held, then ordered drain
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) fifoq.push_back(64'hB0 + W'(k));
    n = 0;
    repeat (6) begin
      tick();
      n += int'(s_rd);
    end
    chk("hold_pops", W'(n), W'(2));
    chk("hold_valid", W'(s_vld), W'(1));
    chk("hold_data", s_dat, 64'hB0);
    out_ready = 1'b1;
    got.delete();
    repeat (10) begin
      tick();
      if (s_vld) got.push_back(s_dat);
    end
    chk("drain_n", W'(got.size()), W'(5));
    for (int k = 0; k < got.size() && k < 5; k++) begin
      chk("drain_ord", got[k], 64'hB0 + W'(k));
    end

    // batch credits over eight streamed pops
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) fifoq.push_back(64'hC0 + W'(k));
    n = 0;
    repeat (30) begin
      tick();
      if (s_cv) begin
        n++;
        chk("batch_cnt", W'(s_cc), W'(4));
      end
    end
    chk("batch_pulses", W'(n), W'(2));

    // pop coincides with timeout expiry
    do_reset();
    out_ready = 1'b1;
    fifoq.push_back(64'hE0);
    fifoq.push_back(64'hE1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 16) fifoq.push_back(64'hE2);
      tick();
      if (s_cv) begin
        n++;
        chk("coin_cnt", W'(s_cc), W'(3));
        chk("coin_when", W'(i), W'(17));
      end
    end
    chk("coin_pulses", W'(n), W'(1));

    // reset while full with three pending credits
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) fifoq.push_back(64'hD0 + W'(k));
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("s2_valid", W'(s_vld), W'(1));
    reset = 1'b1;
    tick();
    chk("rst_no_rd", W'(s_rd), W'(0));
    reset = 1'b0;
    tick();
    chk("rst2_valid", W'(s_vld), W'(0));
    chk("rst2_cv", W'(s_cv), W'(0));
`ifdef ADR_FIFO_READER_STATS_EN
    chk("rst2_count", W'(rd_count), W'(0));
`endif
    out_ready = 1'b1;
    repeat (30) tick();

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && fifoq.size() < 6) begin
        fifoq.push_back({$urandom, $urandom});
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
